// File: rtl/mmul_pkg.sv
// Shared matrix-multiply datapath constants and width helpers, used by the
// multiplier array and the reduction adder tree.
package mmul_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_ACC_GUARD = 5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int sum_width(input int width, input int num_terms);
    return width + clog2(num_terms);
  endfunction

  function automatic int acc_width(input int width, input int num_terms, input int acc_guard);
    return sum_width(width, num_terms) + acc_guard;
  endfunction

endpackage

// File: rtl/add_tree_stage.sv
// One registered level of the reduction tree: PAIRS pairwise adds, each result
// one bit wider than its operands, plus the valid bit that travels with them.
module add_tree_stage #(
  parameter int IN_WIDTH = 32,
  parameter int PAIRS    = 4,
  parameter int SIGNED   = 0
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          in_valid,
  input  logic [2*PAIRS*IN_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  output logic [PAIRS*(IN_WIDTH+1)-1:0] out_data
);

  localparam int OUT_WIDTH = IN_WIDTH + 1;

  logic [PAIRS*OUT_WIDTH-1:0] pair_sum;

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic [IN_WIDTH-1:0] a;
    logic [IN_WIDTH-1:0] b;
    logic                ext_a;
    logic                ext_b;
    assign a     = in_data[2*p*IN_WIDTH +: IN_WIDTH];
    assign b     = in_data[(2*p+1)*IN_WIDTH +: IN_WIDTH];
    assign ext_a = (SIGNED != 0) && a[IN_WIDTH-1];
    assign ext_b = (SIGNED != 0) && b[IN_WIDTH-1];
    assign pair_sum[p*OUT_WIDTH +: OUT_WIDTH] = {ext_a, a} + {ext_b, b};
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) out_valid <= 1'b0;
    else         out_valid <= in_valid;
  end

  // Data is deliberately not reset: invalid beats flow through and only the
  // valid bit decides whether anything downstream uses them.
  always_ff @(posedge Clock) begin
    out_data <= pair_sum;
  end

endmodule

// File: rtl/add_tree_accum.sv
// Pipelined NUM_TERMS-operand reduction adder with optional group accumulator.
// Define ADD_TREE_ACCUM_EN to build the accumulator (in_last / out_ovf active).
module add_tree_accum
  import mmul_pkg::*;
#(
  parameter int NUM_TERMS = 8,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SIGNED    = 0,
  parameter int ACC_GUARD = DEFAULT_ACC_GUARD,
  localparam int LEVELS    = clog2(NUM_TERMS),
  localparam int SUM_WIDTH = sum_width(WIDTH, NUM_TERMS),
  localparam int ACC_WIDTH = acc_width(WIDTH, NUM_TERMS, ACC_GUARD)
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [NUM_TERMS*WIDTH-1:0] in_terms,
  output logic                       out_valid,
  output logic [ACC_WIDTH-1:0]       out_sum,
  output logic                       out_ovf
);

  localparam int PADDED = 1 << LEVELS;

  // Level 0 is the zero-padded input; level s is the output of stage s.
  for (genvar s = 0; s <= LEVELS; s++) begin : lvl
    localparam int LVL_W = WIDTH + s;
    localparam int LVL_N = PADDED >> s;
    logic [LVL_N*LVL_W-1:0] data;
    logic                   valid;
    if (s == 0) begin : g_in
      assign data  = (LVL_N*LVL_W)'(in_terms);
      assign valid = in_valid;
    end else begin : g_stage
      add_tree_stage #(
        .IN_WIDTH (LVL_W - 1),
        .PAIRS    (LVL_N),
        .SIGNED   (SIGNED)
      ) u_stage (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (lvl[s-1].valid),
        .in_data   (lvl[s-1].data),
        .out_valid (valid),
        .out_data  (data)
      );
    end
  end

  logic                 tree_valid;
  logic [SUM_WIDTH-1:0] tree_sum;
  logic [ACC_WIDTH-1:0] tree_ext;

  assign tree_valid = lvl[LEVELS].valid;
  assign tree_sum   = lvl[LEVELS].data;

  if (SIGNED != 0) begin : g_sext
    assign tree_ext = ACC_WIDTH'($signed(tree_sum));
  end else begin : g_zext
    assign tree_ext = ACC_WIDTH'(tree_sum);
  end

`ifdef ADD_TREE_ACCUM_EN
  localparam logic [ACC_GUARD:0] CNT_MAX   = '1;
  localparam logic [ACC_GUARD:0] CNT_LIMIT = (ACC_GUARD+1)'(1 << ACC_GUARD);

  logic [LEVELS-1:0]    last_pipe;
  logic                 tree_last;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_GUARD:0]   cnt;

  // in_last rides alongside the tree so it lines up with the matching sum.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_pipe <= '0;
    end else begin
      last_pipe[0] <= in_last;
      for (int i = 1; i < LEVELS; i++) last_pipe[i] <= last_pipe[i-1];
    end
  end

  assign tree_last = last_pipe[LEVELS-1];
  assign acc_next  = acc + tree_ext;

  // cnt holds the beats already folded into acc, so the closing beat is cnt+1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_valid) begin
        if (tree_last) begin
          out_valid <= 1'b1;
          out_sum   <= acc_next;
          out_ovf   <= (cnt >= CNT_LIMIT);
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_next;
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
      end
    end
  end
`else
  logic [ACC_WIDTH-1:0] held_sum;
  logic                 unused_last;

  assign unused_last = in_last;

  // The tree output changes on invalid beats too, so the last result is held here.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)         held_sum <= '0;
    else if (tree_valid) held_sum <= tree_ext;
  end

  assign out_valid = tree_valid;
  assign out_sum   = tree_valid ? tree_ext : held_sum;
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: doc/add_tree_accum.md
# add_tree_accum

Pipelined, parametrised N-term reduction adder that sums `NUM_TERMS` operands per beat into a result wide enough that no overflow can occur. It optionally accumulates successive beats into one grouped result. It sits after the multiplier array in the matrix-multiply datapath and produces dot-product partial and final sums. It replaces single-pair registered adds with one streaming block that handles valid qualification.

## Interface
Parameters:
- `NUM_TERMS`, 8 — operands per beat; must be ≥ 2; non-power-of-two values are zero-padded to `2**LEVELS`.
- `WIDTH`, 32 — operand width.
- `SIGNED`, 0 — 1: operands are two's complement and are sign-extended; 0: operands are zero-extended.
- `ACC_GUARD`, 5 — extra accumulator bits; a group of up to `2**ACC_GUARD` beats is overflow-free.
- Derived: `LEVELS = $clog2(NUM_TERMS)`, `SUM_WIDTH = WIDTH + LEVELS`, `ACC_WIDTH = SUM_WIDTH + ACC_GUARD`.

Ports:
- `Clock`  in  1  — single clock; all logic is on the rising edge.
- `Resetn`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — `in_terms` is valid this cycle.
- `in_last`  in  1  — last beat of an accumulation group; qualified by `in_valid`.
- `in_terms`  in  `NUM_TERMS*WIDTH`  — packed operands; term k occupies `[k*WIDTH +: WIDTH]`.
- `out_valid`  out  1  — `out_sum` is valid; single-cycle pulse per result.
- `out_sum`  out  `ACC_WIDTH`  — result, sign- or zero-extended according to `SIGNED`.
- `out_ovf`  out  1  — group exceeded `2**ACC_GUARD` beats; qualified by `out_valid`.

## Operation
- No backpressure: the block accepts one beat every cycle and never stalls.
- Tree: `LEVELS` registered stages. Stage s holds `2**(LEVELS-s)` partial sums of width `WIDTH+s`. Each addition extends by one bit, so no truncation occurs anywhere.
- A valid bit travels with each stage. Invalid beats still propagate data but never assert `out_valid`.
- Accumulator (when compiled in):
  - Register `acc` of width `ACC_WIDTH` and a beat counter `cnt` of width `ACC_GUARD+1`, saturating.
  - Tree output valid and not last: `acc <= acc + tree_sum`, `cnt++`.
  - Tree output valid and last: `out_sum <= acc + tree_sum`, `out_valid <= 1`. Then `acc <= 0` and `cnt <= 0` in the same edge, so back-to-back groups need no idle cycle.
  - A single-beat group (`in_last` on the first beat) yields the tree sum.
  - `out_ovf` = 1 when the closing beat is beat number greater than `2**ACC_GUARD`. The sum in that case is modulo `2**ACC_WIDTH`.
- Reset:
  - `out_valid`, `out_sum`, `out_ovf`, `acc`, `cnt`, and all stage valids go to 0.
  - Asserting reset mid-group or mid-pipeline discards every in-flight beat. No partial result is emitted after release.

## Timing
- Without accumulator: latency is `LEVELS` cycles from `in_valid` to `out_valid`. With accumulator: `LEVELS+1` cycles from the closing beat.
- Throughput: one beat per cycle; one result per group (accumulator) or per beat (no accumulator).
- `out_sum` and `out_ovf` hold their values between pulses. They are meaningful only while `out_valid` = 1.
- The first beat may be presented in the first cycle after `Resetn` deasserts.

## Configuration
- `ADD_TREE_ACCUM_EN` defined: accumulator, `cnt`, `in_last`, and `out_ovf` behave as described above.
- Not defined:
  - No accumulator registers are built.
  - Every valid beat produces `out_valid` after `LEVELS` cycles, with `out_sum` equal to the tree sum extended to `ACC_WIDTH`.
  - `in_last` is ignored and `out_ovf` is tied to 0.

## Structure
- Shared package `mmul_pkg` holds:
  - the `clog2` helper function;
  - the width-derivation functions for `SUM_WIDTH` and `ACC_WIDTH`;
  - the default `WIDTH`/`ACC_GUARD` constants, shared with the multiplier array.
- Sub-module `add_tree_stage`: one registered level of pairwise adds with a valid bit, parametrised by input width and pair count. The top instantiates it `LEVELS` times through a generate loop, and the accumulator logic lives in the top.

## Test plan
Default parameters unless noted; `ACC_WIDTH` = 40.
- Unsigned, no accumulator: all 8 terms = `0xFFFFFFFF` → after 3 cycles `out_valid`=1, `out_sum` = `0x07FFFFFFF8`.
- `SIGNED`=1: all terms = `0xFFFFFFFF` (−1) → `out_sum` = −8 (`0xFFFFFFFFF8`). Terms 1..8 → 36.
- Accumulator: 3 consecutive all-`0xFFFFFFFF` beats with `in_last` on the third → one pulse 4 cycles after the third beat, `out_sum` = `0x17FFFFFFE8`, `out_ovf`=0.
- Back-to-back groups: group A is a single beat of all 1s with last; group B is two beats of all 2s, the last carrying `in_last`. No gap between groups → results 8 then 32 on consecutive pulses, and `acc` clears between them.
- Overflow: 33 beats before `in_last` → `out_ovf`=1. With 32 beats → `out_ovf`=0 and the sum is exact.
- Reset: assert `Resetn`=0 during beat 2 of a group → all outputs are 0 immediately. After release, a fresh 1-beat group produces only its own sum.
